// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video constants, FSM state type and grid colour helper
package video_pkg;

    localparam int DEFAULT_HDISP   = 800;
    localparam int DEFAULT_VDISP   = 480;
    localparam int BYTES_PER_PIXEL = 4;
    localparam int GRID_LOG2       = 4;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    localparam logic [15:0] GRID_MASK = 16'((1 << GRID_LOG2) - 1);

    typedef enum logic {
        ST_WRITE = 1'b0,
        ST_GAP   = 1'b1
    } mire_state_t;

    // White on every 16th column and every 16th line, black elsewhere.
    function automatic logic [23:0] grid_pixel(input logic [15:0] x, input logic [15:0] y);
        return (((x & GRID_MASK) == 16'd0) || ((y & GRID_MASK) == 16'd0)) ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone classic bus bundle shared by framebuffer masters and slaves
interface wshb_if (
    input logic clk,
    input logic rst
);

    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  clk, rst, ack, dat_sm,
        output adr, dat_ms, sel, we, cyc, stb, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, sel, we, cyc, stb, cti, bte,
        output ack, dat_sm
    );

endinterface

// File: rtl/mire.sv
// rtl/mire.sv - Wishbone master endlessly writing a 16-pixel white grid into the framebuffer
module mire
    import video_pkg::*;
#(
    parameter int HDISP = DEFAULT_HDISP,
    parameter int VDISP = DEFAULT_VDISP,
    parameter int BURST = 64
) (
    wshb_if.master wshb_ifm
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BURST - 1);
    localparam logic [31:0]   ADR_STEP = 32'(BYTES_PER_PIXEL);

    mire_state_t   state;
    mire_state_t   state_next;
    logic [XW-1:0] x;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y;
    logic [YW-1:0] y_next;
    logic [BW-1:0] b;
    logic [31:0]   adr;
    logic [31:0]   dat;
    logic          cyc;
    logic          take;
    logic          last_pixel;
    logic          unused_dat_sm;

    assign unused_dat_sm = ^wshb_ifm.dat_sm;

    // Gating with rst makes cyc fall the moment reset asserts, not at the next edge.
    always_comb begin
        state_next = state;
        cyc        = 1'b0;
        case (state)
            ST_WRITE: begin
                cyc = ~wshb_ifm.rst;
                if (wshb_ifm.ack && (b == B_LAST)) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_WRITE;
            end
            default: begin
                state_next = ST_WRITE;
            end
        endcase
    end

    assign take       = (state == ST_WRITE) && wshb_ifm.ack;
    assign last_pixel = (x == X_LAST) && (y == Y_LAST);

    always_comb begin
        x_next = x + 1'b1;
        y_next = y;
        if (x == X_LAST) begin
            x_next = '0;
            y_next = (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
        if (wshb_ifm.rst) begin
            state <= ST_WRITE;
            x     <= '0;
            y     <= '0;
            b     <= '0;
            adr   <= '0;
            dat   <= {8'h00, WHITE};
        end else begin
            state <= state_next;
            if (take) begin
                x   <= x_next;
                y   <= y_next;
                b   <= (b == B_LAST) ? '0 : b + 1'b1;
                adr <= last_pixel ? 32'd0 : adr + ADR_STEP;
                // Data is precomputed for the next pixel so it always lines up with adr.
                dat <= {8'h00, grid_pixel(16'(x_next), 16'(y_next))};
            end
        end
    end

    assign wshb_ifm.adr    = adr;
    assign wshb_ifm.dat_ms = dat;
    assign wshb_ifm.sel    = 4'b1111;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.cyc    = cyc;
    assign wshb_ifm.stb    = cyc;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;

endmodule

// File: tb/tb_mire.sv
// tb/tb_mire.sv - randomized self-checking bench for mire against a pixel-index reference model
module tb_mire;

    localparam int H      = 32;
    localparam int V      = 4;
    localparam int BST    = 8;
    localparam int FRAME  = H * V;

    typedef struct {
        logic        cyc;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        ack;
    } tr_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    int  m_n      = 0;
    bit  m_gap    = 0;
    int  wait_cnt = 0;
    int  mode     = 0;
    tr_t trace[$];
    logic [31:0] wr_dat [0:FRAME-1];

    wshb_if wshb (.clk(clk), .rst(rst));

    mire #(.HDISP(H), .VDISP(V), .BURST(BST)) dut (
        .wshb_ifm(wshb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int p);
        int px;
        int py;
        px = p % H;
        py = p / H;
        return ((px % 16 == 0) || (py % 16 == 0)) ? 32'h00FFFFFF : 32'h00000000;
    endfunction

    // Model: the n-th acknowledged write targets pixel n mod FRAME; every BST-th ack is followed by one idle cycle.
    always @(negedge clk) begin
        logic a;
        bit   exp_cyc;
        if (rst) begin
            m_n      = 0;
            m_gap    = 0;
            wait_cnt = 0;
            wshb.ack = 1'b0;
            check("cyc_in_reset", 32'(wshb.cyc), 32'd0);
        end else begin
            exp_cyc = !m_gap;
            check("cyc", 32'(wshb.cyc), 32'(exp_cyc));
            check("stb", 32'(wshb.stb), 32'(wshb.cyc));
            if (exp_cyc) begin
                check("adr", wshb.adr, 32'(4 * (m_n % FRAME)));
                check("dat_ms", wshb.dat_ms, exp_pix(m_n % FRAME));
                check("we_sel", {wshb.we, wshb.sel, wshb.cti, wshb.bte}, {1'b1, 4'hF, 3'd0, 2'd0});
            end
            case (mode)
                0:       a = wshb.cyc;
                1:       a = wshb.cyc && (wait_cnt == 3);
                2:       a = 1'($urandom_range(0, 1));
                default: a = 1'b1;
            endcase
            if (wshb.cyc) wait_cnt = (wait_cnt == 3) ? 0 : wait_cnt + 1;
            else          wait_cnt = 0;
            wshb.ack = a;
            trace.push_back('{wshb.cyc, wshb.adr, wshb.dat_ms, a});
            if (wshb.cyc && a) wr_dat[(wshb.adr / 4) % FRAME] = wshb.dat_ms;
            if (exp_cyc && a) begin
                m_n++;
                if (m_n % BST == 0) m_gap = 1;
            end else if (m_gap) begin
                m_gap = 0;
            end
        end
    end

    initial begin
        bit found;
        wshb.dat_sm = 32'd0;
        wshb.ack    = 1'b0;
        for (int i = 0; i < FRAME; i++) wr_dat[i] = 32'hDEADBEEF;
        rst  = 1'b1;
        mode = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_adr", wshb.adr, 32'd0);
        check("reset_dat", wshb.dat_ms, 32'h00FFFFFF);
        check("reset_cyc", 32'(wshb.cyc), 32'd0);

        @(posedge clk); #2;
        rst = 1'b0;
        trace.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
        end

        // First burst: 0..28, one idle cycle, then 32.
        check("trace_len", 32'(trace.size() >= 10), 32'd1);
        if (trace.size() >= 10) begin
            for (int i = 0; i < 8; i++) begin
                check("burst_cyc", 32'(trace[i].cyc), 32'd1);
                check("burst_adr", trace[i].adr, 32'(4 * i));
            end
            check("first_dat", trace[0].dat, 32'h00FFFFFF);
            check("gap_cyc", 32'(trace[8].cyc), 32'd0);
            check("after_gap_cyc", 32'(trace[9].cyc), 32'd1);
            check("after_gap_adr", trace[9].adr, 32'd32);
        end

        check("pix_0_0", wr_dat[0], 32'h00FFFFFF);
        check("pix_0_2", wr_dat[2 * H], 32'h00FFFFFF);
        check("pix_16_1", wr_dat[H + 16], 32'h00FFFFFF);
        check("pix_16_3", wr_dat[3 * H + 16], 32'h00FFFFFF);
        check("pix_5_0", wr_dat[5], 32'h00FFFFFF);
        check("pix_1_1", wr_dat[H + 1], 32'h00000000);
        check("pix_17_3", wr_dat[3 * H + 17], 32'h00000000);

        found = 0;
        for (int i = 0; i + 2 < trace.size(); i++) begin
            if (!found && trace[i].cyc && trace[i].ack && trace[i].adr == 32'd508) begin
                found = 1;
                check("wrap_gap", 32'(trace[i + 1].cyc), 32'd0);
                check("wrap_adr", trace[i + 2].adr, 32'd0);
                check("wrap_cyc", 32'(trace[i + 2].cyc), 32'd1);
            end
        end
        check("wrap_seen", 32'(found), 32'd1);

        @(posedge clk); #2;
        mode = 1;
        repeat (120) @(posedge clk);
        #2;
        mode = 3;
        trace.delete();
        repeat (60) @(posedge clk);
        #2;
        found = 0;
        for (int i = 1; i + 1 < trace.size(); i++) begin
            if (!found && !trace[i].cyc && trace[i].ack && trace[i - 1].cyc) begin
                found = 1;
                check("gap_ack_adr", trace[i + 1].adr, (trace[i - 1].adr + 32'd4) % 32'd512);
            end
        end
        check("gap_ack_seen", 32'(found), 32'd1);

        mode = 2;
        repeat (500) @(posedge clk);
        #2;

        rst = 1'b1;
        @(posedge clk); #2;
        rst  = 1'b0;
        mode = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #1;
            if (wshb.cyc && wshb.adr == 32'd40) found = 1;
        end
        check("reach_adr40", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_cyc", 32'(wshb.cyc), 32'd0);
        check("midrst_adr", wshb.adr, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #1;
        check("restart_cyc", 32'(wshb.cyc), 32'd1);
        check("restart_adr", wshb.adr, 32'd0);
        check("restart_dat", wshb.dat_ms, 32'h00FFFFFF);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
